// File: rtl/monster_spawner.sv
// Monster spawn sequencer: game phase FSM, two lane FSMs with LFSR-driven spawn delays,
// kill detection from the block controller's visibility feedback, and saturating score.
module monster_spawner #(
    parameter int         MIN_DELAY     = 32,
    parameter int         ATTACK_CYCLES = 200,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       top_monster_vga,
    input  logic       btm_monster_vga,
    output logic       top_monster_ctrl,
    output logic       btm_monster_ctrl,
    output logic       top_broken,
    output logic       btm_broken,
    output logic [7:0] score,
    output logic       game_over
);
    typedef enum logic [1:0] {PH_IDLE, PH_PLAY, PH_OVER} phase_t;
    typedef enum logic [1:0] {LN_OFF, LN_WAIT, LN_ALIVE, LN_BROKEN} lane_t;

    localparam int TOP = 0;
    localparam int BTM = 1;

    phase_t          phase, phase_next;
    lane_t           lane      [2];
    lane_t           lane_next [2];
    logic [1:0][6:0] wait_cnt, wait_next, delay;
    logic [1:0][7:0] age, age_next;
    logic [1:0]      vga, vga_prev, ctrl_reg, kill_now, broken;
    logic [7:0]      lfsr, lfsr_next, score_next;
    logic [8:0]      score_sum;
    logic [5:0]      top_rnd, btm_rnd;
    logic            start_game;

    assign vga        = {btm_monster_vga, top_monster_vga};
    assign start_game = start && (phase != PH_PLAY);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ctrl_reg[i] = (lane[i] == LN_ALIVE);
            broken[i]   = (lane[i] == LN_BROKEN);
        end
    end

    // A falling visibility flag while requested is a hit; gating ctrl here keeps the
    // block controller from re-sampling a stale request on the next edge.
    assign kill_now         = ctrl_reg & vga_prev & ~vga;
    assign top_monster_ctrl = ctrl_reg[TOP] & ~kill_now[TOP];
    assign btm_monster_ctrl = ctrl_reg[BTM] & ~kill_now[BTM];
    assign top_broken       = broken[TOP];
    assign btm_broken       = broken[BTM];
    assign game_over        = (phase == PH_OVER);

    // A game start samples the seed even though the register may still hold an old value.
    assign top_rnd    = start_game ? LFSR_SEED[5:0] : lfsr[5:0];
    assign btm_rnd    = start_game ? {LFSR_SEED[2:0], LFSR_SEED[7:5]} : {lfsr[2:0], lfsr[7:5]};
    assign delay[TOP] = 7'(MIN_DELAY) + {1'b0, top_rnd};
    assign delay[BTM] = 7'(MIN_DELAY) + {1'b0, btm_rnd};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        phase_next = phase;
        case (phase)
            PH_IDLE: if (start) phase_next = PH_PLAY;
            PH_PLAY: if (&broken) phase_next = PH_OVER;
            PH_OVER: if (start) phase_next = PH_PLAY;
            default: phase_next = PH_IDLE;
        endcase
    end

    always_comb begin
        lfsr_next = lfsr;
        if (start_game)
            lfsr_next = LFSR_SEED;
        else if (phase == PH_PLAY)
            lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

        score_sum  = {1'b0, score} + 9'(kill_now[TOP]) + 9'(kill_now[BTM]);
        score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
        if (start_game)
            score_next = '0;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_next[i] = lane[i];
            wait_next[i] = wait_cnt[i];
            age_next[i]  = age[i];
            if (start_game) begin
                lane_next[i] = LN_WAIT;
                wait_next[i] = delay[i];
                age_next[i]  = '0;
            end else if (phase == PH_PLAY) begin
                case (lane[i])
                    LN_WAIT: begin
                        if (wait_cnt[i] == 7'd1) begin
                            lane_next[i] = LN_ALIVE;
                            age_next[i]  = 8'd1;
                        end else begin
                            wait_next[i] = wait_cnt[i] - 7'd1;
                        end
                    end
                    LN_ALIVE: begin
                        // A hit on the timeout edge still counts as a kill.
                        if (kill_now[i]) begin
                            lane_next[i] = LN_WAIT;
                            wait_next[i] = delay[i];
                        end else if (age[i] == 8'(ATTACK_CYCLES)) begin
                            lane_next[i] = LN_BROKEN;
                        end else begin
                            age_next[i] = age[i] + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase    <= PH_IDLE;
            lfsr     <= LFSR_SEED;
            score    <= '0;
            vga_prev <= '0;
            wait_cnt <= '0;
            age      <= '0;
            for (int i = 0; i < 2; i++)
                lane[i] <= LN_OFF;
        end else begin
            phase    <= phase_next;
            lfsr     <= lfsr_next;
            score    <= score_next;
            vga_prev <= vga;
            wait_cnt <= wait_next;
            age      <= age_next;
            for (int i = 0; i < 2; i++)
                lane[i] <= lane_next[i];
        end
    end

endmodule

// File: tb/tb_monster_spawner.sv
// Directed bench for monster_spawner: spawn timing, kills, timeouts, restart, reset, saturation.
module tb_monster_spawner;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start = 1'b0;
    logic       top_monster_vga = 1'b0;
    logic       btm_monster_vga = 1'b0;
    logic       top_monster_ctrl, btm_monster_ctrl, top_broken, btm_broken, game_over;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int t_top  = 0;

    monster_spawner dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .start            (start),
        .top_monster_vga  (top_monster_vga),
        .btm_monster_vga  (btm_monster_vga),
        .top_monster_ctrl (top_monster_ctrl),
        .btm_monster_ctrl (btm_monster_ctrl),
        .top_broken       (top_broken),
        .btm_broken       (btm_broken),
        .score            (score),
        .game_over        (game_over)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        edge_n++;
        #1;
    endtask

    task automatic wait_until(input int n);
        while (edge_n < n) tick();
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        checks++; if ({top_monster_ctrl, btm_monster_ctrl, top_broken, btm_broken, score, game_over} !== 13'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want all zero", {top_monster_ctrl, btm_monster_ctrl, top_broken, btm_broken, score, game_over}); end
        Reset_n = 1'b1;
        tick();
        checks++; if ({top_monster_ctrl, btm_monster_ctrl, score, game_over} !== 11'd0) begin
            errors++; $display("FAIL idle_outputs: got %b want all zero", {top_monster_ctrl, btm_monster_ctrl, score, game_over}); end
    endtask

    // Seeded delays are 32+37 (top) and 32+45 (bottom) edges after the game-start edge.
    task automatic spawn_timing(input string tag);
        wait_until(68);
        checks++; if (top_monster_ctrl !== 1'b0) begin errors++; $display("FAIL %s_top_e68: got %b want 0", tag, top_monster_ctrl); end
        tick();
        checks++; if (top_monster_ctrl !== 1'b1) begin errors++; $display("FAIL %s_top_e69: got %b want 1", tag, top_monster_ctrl); end
        checks++; if (btm_monster_ctrl !== 1'b0) begin errors++; $display("FAIL %s_btm_e69: got %b want 0", tag, btm_monster_ctrl); end
        wait_until(76);
        checks++; if (btm_monster_ctrl !== 1'b0) begin errors++; $display("FAIL %s_btm_e76: got %b want 0", tag, btm_monster_ctrl); end
        tick();
        checks++; if (btm_monster_ctrl !== 1'b1) begin errors++; $display("FAIL %s_btm_e77: got %b want 1", tag, btm_monster_ctrl); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL %s_score: got %0d want 0", tag, score); end
    endtask

    task automatic test_spawn();
        start = 1'b1;
        edge_n = -1;
        tick();
        start = 1'b0;
        spawn_timing("spawn");
    endtask

    task automatic test_kill();
        logic [7:0] x;
        int d2;
        top_monster_vga = 1'b1;
        tick();
        checks++; if (top_monster_ctrl !== 1'b1) begin errors++; $display("FAIL kill_pre_ctrl: got %b want 1", top_monster_ctrl); end
        top_monster_vga = 1'b0;
        #1;
        checks++; if (top_monster_ctrl !== 1'b0) begin errors++; $display("FAIL kill_comb_ctrl: got %b want 0", top_monster_ctrl); end
        tick();
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL kill_score: got %0d want 1", score); end
        checks++; if (top_monster_ctrl !== 1'b0) begin errors++; $display("FAIL kill_wait_ctrl: got %b want 0", top_monster_ctrl); end
        // Kill edge 79 samples the LFSR after 78 advances from the seed.
        x = 8'hA5;
        repeat (78) x = lfsr_step(x);
        d2 = 32 + int'(x[5:0]);
        t_top = 79 + d2;
        wait_until(t_top - 1);
        checks++; if (top_monster_ctrl !== 1'b0) begin errors++; $display("FAIL respawn_early: got %b want 0 at edge %0d", top_monster_ctrl, edge_n); end
        tick();
        checks++; if (top_monster_ctrl !== 1'b1) begin errors++; $display("FAIL respawn_edge: got %b want 1 at edge %0d", top_monster_ctrl, edge_n); end
    endtask

    task automatic test_timeout();
        wait_until(276);
        checks++; if ({btm_monster_ctrl, btm_broken} !== 2'b10) begin errors++; $display("FAIL btm_e276: got ctrl,broken=%b want 10", {btm_monster_ctrl, btm_broken}); end
        tick();
        checks++; if ({btm_monster_ctrl, btm_broken, game_over} !== 3'b010) begin errors++; $display("FAIL btm_e277: got ctrl,broken,over=%b want 010", {btm_monster_ctrl, btm_broken, game_over}); end
        wait_until(t_top + 199);
        checks++; if ({top_monster_ctrl, top_broken} !== 2'b10) begin errors++; $display("FAIL top_pre_break: got ctrl,broken=%b want 10", {top_monster_ctrl, top_broken}); end
        tick();
        checks++; if ({top_monster_ctrl, top_broken, game_over} !== 3'b010) begin errors++; $display("FAIL top_break: got ctrl,broken,over=%b want 010", {top_monster_ctrl, top_broken, game_over}); end
        tick();
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL game_over: got %b want 1", game_over); end
        repeat (3) begin
            top_monster_vga = 1'b1;
            tick();
            top_monster_vga = 1'b0;
            tick();
        end
        checks++; if ({score, game_over} !== {8'd1, 1'b1}) begin errors++; $display("FAIL over_frozen: got score=%0d over=%b want 1,1", score, game_over); end
    endtask

    task automatic test_restart();
        start = 1'b1;
        edge_n = -1;
        tick();
        checks++; if ({score, top_broken, btm_broken, game_over} !== 11'd0) begin
            errors++; $display("FAIL restart_clear: got score=%0d tb=%b bb=%b over=%b want all zero", score, top_broken, btm_broken, game_over); end
        repeat (4) tick();
        start = 1'b0;
        spawn_timing("restart");
    endtask

    task automatic test_kill_at_timeout();
        wait_until(267);
        top_monster_vga = 1'b1;
        tick();
        checks++; if (top_monster_ctrl !== 1'b1) begin errors++; $display("FAIL kt_pre_ctrl: got %b want 1", top_monster_ctrl); end
        top_monster_vga = 1'b0;
        tick();
        checks++; if ({top_broken, top_monster_ctrl, score} !== {1'b0, 1'b0, 8'd1}) begin
            errors++; $display("FAIL kill_vs_timeout: got broken=%b ctrl=%b score=%0d want 0,0,1", top_broken, top_monster_ctrl, score); end
    endtask

    task automatic test_async_reset();
        checks++; if (btm_monster_ctrl !== 1'b1) begin errors++; $display("FAIL ar_pre_ctrl: got %b want 1", btm_monster_ctrl); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if ({top_monster_ctrl, btm_monster_ctrl, top_broken, btm_broken, score, game_over} !== 13'd0) begin
            errors++; $display("FAIL ar_immediate: got %b want all zero", {top_monster_ctrl, btm_monster_ctrl, top_broken, btm_broken, score, game_over}); end
        Reset_n = 1'b1;
        tick();
        tick();
        checks++; if ({top_monster_ctrl, btm_monster_ctrl, top_broken, btm_broken, score, game_over} !== 13'd0) begin
            errors++; $display("FAIL ar_released: got %b want all zero", {top_monster_ctrl, btm_monster_ctrl, top_broken, btm_broken, score, game_over}); end
    endtask

    task automatic test_saturation();
        int budget;
        start = 1'b1;
        edge_n = -1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 128; k++) begin
            budget = 0;
            while (!(top_monster_ctrl && btm_monster_ctrl) && budget < 300) begin
                tick();
                budget++;
            end
            checks++; if (budget >= 300) begin errors++; $display("FAIL sat_wait: both lanes not alive, iter %0d", k); break; end
            top_monster_vga = 1'b1;
            btm_monster_vga = 1'b1;
            tick();
            top_monster_vga = 1'b0;
            btm_monster_vga = 1'b0;
            tick();
            if (k == 126) begin
                checks++; if (score !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", score); end
            end
        end
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_double: got %0d want 255", score); end
        budget = 0;
        while (!top_monster_ctrl && budget < 300) begin
            tick();
            budget++;
        end
        checks++; if (budget >= 300) begin errors++; $display("FAIL sat_single_wait: top lane not alive"); end
        top_monster_vga = 1'b1;
        tick();
        top_monster_vga = 1'b0;
        #1;
        checks++; if (top_monster_ctrl !== 1'b0) begin errors++; $display("FAIL sat_single_kill: got ctrl %b want 0", top_monster_ctrl); end
        tick();
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", score); end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_kill();
        test_timeout();
        test_restart();
        test_kill_at_timeout();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
